// File: rtl/jpeg_idct_transpose_ctrl.sv
// ============================================================================
// Module  : jpeg_idct_transpose_ctrl
// Purpose : Packs one 8x8 row-pass block into the transpose RAM and streams it
//           back out in column-major order for the IDCT column pass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jpeg_idct_transpose_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inp_valid_i,
  input  logic [15:0] inp_data_i,
  output logic        inp_ready_o,
  output logic        outp_valid_o,
  output logic [15:0] outp_data_o,
  output logic [5:0]  outp_idx_o,
  output logic        outp_last_o,
  input  logic        outp_ready_i,
  output logic [4:0]  ram_addr0_o,
  output logic [31:0] ram_data0_o,
  output logic        ram_wr0_o,
  output logic [4:0]  ram_addr1_o,
  input  logic [31:0] ram_data1_i
);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_run;
  logic [5:0]  r_wcnt;
  logic [15:0] r_even;
  logic        r_valid;
  logic [5:0]  r_idx;
  logic        r_col0;

  logic        w_accept;
  logic        w_xfer;
  logic        w_xfer_last;
  logic [5:0]  w_fetch;

  assign inp_ready_o = r_run & (r_state == ST_FILL);
  assign w_accept    = inp_valid_i & inp_ready_o;
  assign w_xfer      = r_valid & outp_ready_i;
  assign w_xfer_last = w_xfer & (r_idx == 6'd63);

  // Index whose word the RAM latches at the next edge: advance on a transfer,
  // otherwise re-read the presented sample so a stall needs no skid register.
  assign w_fetch     = w_xfer ? (r_idx + 6'd1) : r_idx;
  assign ram_addr1_o = {w_fetch[2:0], w_fetch[5:4]};

  assign ram_wr0_o   = w_accept & r_wcnt[0];
  assign ram_addr0_o = ram_wr0_o ? r_wcnt[5:1] : 5'd0;
  assign ram_data0_o = ram_wr0_o ? {inp_data_i, r_even} : 32'd0;

  assign outp_valid_o = r_valid;
  assign outp_idx_o   = r_idx;
  assign outp_last_o  = r_valid & (r_idx == 6'd63);
  assign outp_data_o  = !r_valid ? 16'd0 :
                        (r_col0 ? ram_data1_i[31:16] : ram_data1_i[15:0]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL:  if (w_accept && (r_wcnt == 6'd63)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_xfer_last)                   w_state_nxt = ST_FILL;
      default:                                     w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_run  <= 1'b0;
      r_wcnt <= 6'd0;
      r_even <= 16'd0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_wcnt <= r_wcnt + 6'd1;
        if (!r_wcnt[0]) r_even <= inp_data_i;
      end
    end
  end

  // The RAM read issued at the edge that raises r_valid carries the first
  // sample, so valid and data align without an extra pipeline flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_idx   <= 6'd0;
      r_col0  <= 1'b0;
    end else if (r_state == ST_DRAIN) begin
      if (w_xfer_last) begin
        r_valid <= 1'b0;
        r_idx   <= 6'd0;
        r_col0  <= 1'b0;
      end else begin
        r_valid <= 1'b1;
        r_idx   <= w_fetch;
        r_col0  <= w_fetch[3];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// ============================================================================
// Module  : tb_jpeg_idct_transpose_ctrl
// Purpose : Scoreboard bench for the IDCT transpose sequencer with a RAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jpeg_idct_transpose_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        inp_valid_i = 1'b0;
  logic [15:0] inp_data_i = 16'd0;
  logic        inp_ready_o;
  logic        outp_valid_o;
  logic [15:0] outp_data_o;
  logic [5:0]  outp_idx_o;
  logic        outp_last_o;
  logic        outp_ready_i = 1'b1;
  logic [4:0]  ram_addr0_o;
  logic [31:0] ram_data0_o;
  logic        ram_wr0_o;
  logic [4:0]  ram_addr1_o;
  logic [31:0] ram_data1_i = 32'd0;

  jpeg_idct_transpose_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inp_valid_i  (inp_valid_i),
    .inp_data_i   (inp_data_i),
    .inp_ready_o  (inp_ready_o),
    .outp_valid_o (outp_valid_o),
    .outp_data_o  (outp_data_o),
    .outp_idx_o   (outp_idx_o),
    .outp_last_o  (outp_last_o),
    .outp_ready_i (outp_ready_i),
    .ram_addr0_o  (ram_addr0_o),
    .ram_data0_o  (ram_data0_o),
    .ram_wr0_o    (ram_wr0_o),
    .ram_addr1_o  (ram_addr1_o),
    .ram_data1_i  (ram_data1_i)
  );

  always #5 clk_i = ~clk_i;

  // Transpose RAM: write port 0, registered read port 1.
  logic [31:0] mem [32];
  always @(posedge clk_i) begin
    if (ram_wr0_o) mem[ram_addr0_o] <= ram_data0_o;
    ram_data1_i <= mem[ram_addr1_o];
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic [5:0]  idx;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] blk [64];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  bit          bp      = 1'b0;
  bit          first_pending = 1'b0;
  int          first_edge = 0;
  bit          after_last = 1'b0;
  bit          stalled = 1'b0;
  logic [15:0] st_d;
  logic [5:0]  st_idx;
  logic        st_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: column-major readout of the accepted row-major block.
  task automatic push_expected(input logic [15:0] b [64]);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) begin
        exp_t e;
        e.d   = b[r*8 + c];
        e.idx = 6'(c*8 + r);
        sb.push_back(e);
      end
  endtask

  task automatic feed_block(input int gap);
    logic [15:0] acc [64];
    for (int i = 0; i < 64; i++) begin
      int  t;
      bit  ok;
      for (int g = 0; g < gap; g++) begin
        inp_valid_i = 1'b0;
        @(posedge clk_i); #1;
      end
      inp_valid_i = 1'b1;
      inp_data_i  = blk[i];
      t = 0;
      forever begin
        @(negedge clk_i); ok = inp_ready_o;
        @(posedge clk_i); #1;
        if (ok) break;
        t++;
        if (t > 400) begin
          check("input_accept_timeout", 32'd1, 32'd0);
          inp_valid_i = 1'b0;
          return;
        end
      end
      acc[i] = blk[i];
    end
    push_expected(acc);
    first_edge    = cyc;
    first_pending = 1'b1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || outp_valid_o) && t < 2000) begin
      @(posedge clk_i); #1;
      t++;
    end
    check("drain_done", {31'd0, (t >= 2000)}, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk_i); #1;
      outp_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      stalled    = 1'b0;
      after_last = 1'b0;
    end else begin
      if (first_pending) begin
        if (cyc == first_edge) check("bubble_valid", {31'd0, outp_valid_o}, 32'd0);
        else if (cyc == first_edge + 1) begin
          check("first_valid_latency", {31'd0, outp_valid_o}, 32'd1);
          first_pending = 1'b0;
        end
      end
      if (after_last) begin
        check("ready_after_last", {31'd0, inp_ready_o}, 32'd1);
        check("valid_after_last", {31'd0, outp_valid_o}, 32'd0);
        after_last = 1'b0;
      end
      if (outp_valid_o) check("inp_ready_in_drain", {31'd0, inp_ready_o}, 32'd0);
      if (stalled) begin
        check("stall_valid", {31'd0, outp_valid_o}, 32'd1);
        check("stall_data", {16'd0, outp_data_o}, {16'd0, st_d});
        check("stall_idx", {26'd0, outp_idx_o}, {26'd0, st_idx});
        check("stall_last", {31'd0, outp_last_o}, {31'd0, st_last});
      end
      if (outp_valid_o && outp_ready_i) begin
        if (sb.size() == 0) check("unexpected_output", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", {16'd0, outp_data_o}, {16'd0, e.d});
          check("out_idx", {26'd0, outp_idx_o}, {26'd0, e.idx});
          check("out_last", {31'd0, outp_last_o}, {31'd0, (e.idx == 6'd63)});
        end
        n_out++;
        if (outp_last_o) after_last = 1'b1;
      end
      stalled = outp_valid_o && !outp_ready_i;
      st_d    = outp_data_o;
      st_idx  = outp_idx_o;
      st_last = outp_last_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, outp_valid_o}, 32'd0);
    check({tag, "_data"},  {16'd0, outp_data_o}, 32'd0);
    check({tag, "_idx"},   {26'd0, outp_idx_o}, 32'd0);
    check({tag, "_last"},  {31'd0, outp_last_o}, 32'd0);
    check({tag, "_wr0"},   {31'd0, ram_wr0_o}, 32'd0);
    check({tag, "_addr0"}, {27'd0, ram_addr0_o}, 32'd0);
    check({tag, "_addr1"}, {27'd0, ram_addr1_o}, 32'd0);
    check({tag, "_data0"}, ram_data0_o, 32'd0);
    check({tag, "_ready"}, {31'd0, inp_ready_o}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 check("ready_before_clock", {31'd0, inp_ready_o}, 32'd0);
    @(posedge clk_i); #1;
    check("ready_after_release", {31'd0, inp_ready_o}, 32'd1);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk_i);
    #1 check_reset_outputs("por");
    release_reset();

    // Ramp
    for (int i = 0; i < 64; i++) blk[i] = 16'(i);
    feed_block(0);
    wait_drain();

    // Signed pattern
    for (int i = 0; i < 64; i++) blk[i] = 16'(-i);
    feed_block(0);
    wait_drain();

    // Random data under random backpressure
    bp = 1'b1;
    for (int i = 0; i < 64; i++) blk[i] = 16'($urandom);
    feed_block(0);
    wait_drain();
    for (int i = 0; i < 64; i++) blk[i] = 16'(i);
    feed_block(0);
    wait_drain();
    bp = 1'b0;

    // Input gaps: valid every third cycle, then inspect packed RAM words
    feed_block(2);
    inp_valid_i = 1'b0;
    check("ram_word0",  mem[0],  32'h0001_0000);
    check("ram_word5",  mem[5],  32'h000B_000A);
    check("ram_word31", mem[31], 32'h003F_003E);
    wait_drain();

    // Back-to-back blocks with valid held high
    for (int i = 0; i < 64; i++) blk[i] = 16'(i);
    feed_block(0);
    for (int i = 0; i < 64; i++) blk[i] = 16'(100 + i);
    feed_block(0);
    inp_valid_i = 1'b0;
    wait_drain();

    // Reset in the middle of a drain
    for (int i = 0; i < 64; i++) blk[i] = 16'(i);
    t = n_out;
    feed_block(0);
    inp_valid_i = 1'b0;
    begin
      int w = 0;
      while (n_out < t + 20 && w < 500) begin
        @(negedge clk_i);
        w++;
      end
      check("reach_20_outputs", {31'd0, (w >= 500)}, 32'd0);
    end
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1 check_reset_outputs("mid_drain_rst");
    sb.delete();
    first_pending = 1'b0;
    repeat (2) @(posedge clk_i);
    release_reset();
    feed_block(0);
    inp_valid_i = 1'b0;
    wait_drain();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jpeg_idct_transpose_ctrl.md
# jpeg_idct_transpose_ctrl

Sequencer between the IDCT row pass and the IDCT column pass. It accepts one 8x8 block of 16-bit row-pass results in row-major order and packs them in pairs into the 32x32 transpose RAM. It then reads the block back in column-major order and streams the samples to the column pass over a valid/ready handshake. The block owns both RAM ports: port 0 for writes and port 1 for reads. The RAM has registered reads with 1-cycle latency and is never written while being drained.

## Interface
Parameters: none; widths are fixed.

Ports:
- clk_i  in  1  single clock; drives the RAM clk0_i and clk1_i.
- rst_i  in  1  asynchronous, active-low reset.
- inp_valid_i  in  1  row-pass sample valid.
- inp_data_i  in  16  row-pass sample, signed.
- inp_ready_o  out  1  sample accepted when high together with valid.
- outp_valid_o  out  1  column-order sample valid.
- outp_data_o  out  16  column-order sample.
- outp_idx_o  out  6  column-major index, equal to col*8+row.
- outp_last_o  out  1  high with the 64th sample of the block.
- outp_ready_i  in  1  column pass accepts the sample.
- ram_addr0_o  out  5  write address.
- ram_data0_o  out  32  write data.
- ram_wr0_o  out  1  write strobe.
- ram_addr1_o  out  5  read address.
- ram_data1_i  in  32  registered read data, valid the cycle after the address.

## Operation
- RAM layout: sample (row r, col c) is stored at word {r[2:0], c[2:1]}.
  - Even c goes in bits [15:0].
  - Odd c goes in bits [31:16].
- States:
  - FILL (reset state): inp_ready_o=1. A 6-bit write counter wcnt counts accepted samples.
    - Accepted sample with wcnt[0]=0: held in a 16-bit even register.
    - Accepted sample with wcnt[0]=1: write fires the same cycle, with ram_wr0_o=1, ram_addr0_o=wcnt[5:1], ram_data0_o={inp_data_i, even_q}.
    - When the sample with wcnt=63 is accepted, the next state is DRAIN.
  - DRAIN: inp_ready_o=0. A 6-bit read counter rcnt walks 0..63, with col=rcnt[5:3] and row=rcnt[2:0].
    - Read address = {row, col[2:1]}.
    - Output half = col[0] ? ram_data1_i[31:16] : ram_data1_i[15:0], using col[0] registered alongside the address.
    - A transfer occurs when outp_valid_o and outp_ready_i are both high. On the transfer with outp_last_o=1, the next state is FILL.
- Read pointer: while outp_valid_o=1 and outp_ready_i=0, ram_addr1_o holds the current address. Because the RAM is static during DRAIN, re-reading returns identical data and no skid register is needed.
- outp_idx_o = rcnt of the presented sample. outp_last_o = (outp_idx_o==63) & outp_valid_o.
- Data is passed through unmodified; the block does no arithmetic.
- ram_wr0_o is never asserted in DRAIN. ram_addr0_o and ram_data0_o are don't-care when ram_wr0_o=0.
- Reset, asserted at any time including mid-FILL or mid-DRAIN:
  - Asynchronously: state=FILL, wcnt=rcnt=0, even_q=0.
  - Outputs: outp_valid_o=0, outp_data_o=0, outp_idx_o=0, outp_last_o=0, ram_wr0_o=0, ram_addr0_o=0, ram_addr1_o=0, ram_data0_o=0.
  - inp_ready_o goes to 1 on the first clock after release.
  - A partial block is discarded.

## Timing
- Input side accepts 1 sample/cycle. 64 samples produce 32 RAM writes, one every second accepted sample.
- Last input accepted at edge N:
  - The final write lands at edge N.
  - Address for rcnt=0 is driven after N and sampled at N+1.
  - outp_valid_o=1 from edge N+1, i.e. 1 cycle of bubble after the last accept. The last write is visible to that read.
- With outp_ready_i held high, the output side delivers 1 sample/cycle. Drain takes 64 cycles.
- After the last-sample transfer at edge M:
  - outp_valid_o=0 and inp_ready_o=1 from M.
  - A new block can be accepted in the cycle after M, so there is no overlap between blocks.
- Output handshake: once outp_valid_o=1, outp_data_o, outp_idx_o and outp_last_o stay stable until the transfer.
- Input gaps (inp_valid_i=0) only pause wcnt; even_q is held across gaps.

## Test plan
- Ramp: input 0..63 with outp_ready_i=1. Required output sequence: 0,8,16,...,56,1,9,...,63; outp_idx_o 0..63; outp_last_o only on value 63; first outp_valid_o one cycle after the last inp accept.
- Signed pattern: input -i for i=0..63. Output (col c, row r) = -(r*8+c), confirming sign bits are preserved in both RAM halves.
- Backpressure: outp_ready_i toggles randomly (50%) during drain. Same 64-value sequence with no duplicates or drops; data stable while stalled.
- Input gaps: inp_valid_i=1 every third cycle. RAM words match a ramp load (e.g. word 0 = 0x00010000), and the output order matches the ramp case.
- Back-to-back blocks: block A (0..63) then block B (100..163), with inp_valid_i held high. inp_ready_o=0 throughout A's drain; B accepted starting the cycle after A's last transfer; B output 100,108,...,163.
- Reset mid-drain: assert rst_i after 20 outputs. All outputs take their reset values immediately; after release, a fresh ramp block drains correctly starting at idx 0.
